// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - store buffer size encodings, entry type and byte-lane helpers
package sb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] base;
        logic [3:0]  mask;
        logic [31:0] data;
    } sb_entry_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << off;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && (off == 2'd3)) || (size[1] && (off != 2'd0));
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core request/response and data memory port bundle
interface store_buffer_if #(parameter int ADDR_WIDTH = 32);
    logic                  LD_REQ;
    logic                  ST_REQ;
    logic [1:0]            SIZE;
    logic                  UNSIGNED;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [31:0]           WD;
    logic                  FLUSH;
    logic [31:0]           RD;
    logic                  MISALIGN;
    logic                  STALL;
    logic                  MEM_WE;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [31:0]           MEM_WD;
    logic [31:0]           MEM_RD;

    modport slave (
        input  LD_REQ, ST_REQ, SIZE, UNSIGNED, ADDR, WD, FLUSH, MEM_RD,
        output RD, MISALIGN, STALL, MEM_WE, MEM_ADDR, MEM_WD
    );

    modport master (
        output LD_REQ, ST_REQ, SIZE, UNSIGNED, ADDR, WD, FLUSH, MEM_RD,
        input  RD, MISALIGN, STALL, MEM_WE, MEM_ADDR, MEM_WD
    );
endinterface

// File: rtl/sb_lane_align.sv
// rtl/sb_lane_align.sv - byte-lane shifter: store right-align->lane, load lane->right-align+extend
module sb_lane_align
    import sb_pkg::*;
#(
    parameter bit IS_LOAD = 1'b0
) (
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [4:0]  w_sh;
    logic [31:0] w_shift;
    logic [31:0] w_ext;

    assign w_sh    = {i_off, 3'b000};
    assign w_shift = IS_LOAD ? (i_data >> w_sh) : (i_data << w_sh);

    always_comb begin
        w_ext = w_shift;
        case (i_size)
            SZ_BYTE: w_ext = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
            SZ_HALF: w_ext = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    assign o_data = IS_LOAD ? w_ext : w_shift;
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO with coalescing, idle-cycle drain and load forwarding
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t       r_entries [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic [ADDR_WIDTH-1:0] w_base;
    logic [31:0]     w_base32;
    logic [1:0]      w_off;
    logic [3:0]      w_mask;
    logic            w_mis, w_st, w_ld;
    logic            w_empty, w_full, w_young_hit;
    logic            w_drain, w_coal, w_push;
    logic [PW-1:0]   w_young_idx;
    logic [31:0]     w_st_lane, w_fwd_word, w_ld_data;

    assign w_base      = {bus.ADDR[ADDR_WIDTH-1:2], 2'b00};
    assign w_base32    = 32'(w_base);
    assign w_off       = bus.ADDR[1:0];
    assign w_mask      = size_mask(bus.SIZE, w_off);
    assign w_mis       = !reset && (bus.LD_REQ || bus.ST_REQ) && misaligned(bus.SIZE, w_off);
    assign w_st        = !reset && bus.ST_REQ && !w_mis;
    assign w_ld        = !reset && bus.LD_REQ && !bus.ST_REQ && !w_mis;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_young_idx = r_tail - PW'(1);
    assign w_young_hit = !w_empty && (r_entries[w_young_idx].base == w_base32);

    // A raised LD_REQ reserves the port even when a store wins the request;
    // only a full buffer taking a non-coalescing store forces the head out.
    assign w_drain = !reset && !w_empty && !w_mis &&
                     (!bus.LD_REQ || (w_st && w_full && !w_young_hit));
    // Never merge into the entry leaving this cycle, or the new bytes would be lost.
    assign w_coal  = w_st && w_young_hit && !(w_drain && (r_count == CW'(1)));
    assign w_push  = w_st && !w_coal;

    sb_lane_align #(.IS_LOAD(1'b0)) u_st_align (
        .i_data     (bus.WD),
        .i_off      (w_off),
        .i_size     (bus.SIZE),
        .i_unsigned (bus.UNSIGNED),
        .o_data     (w_st_lane)
    );

    always_comb begin
        w_fwd_word = bus.MEM_RD;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && r_entries[r_head + PW'(i)].valid &&
                (r_entries[r_head + PW'(i)].base == w_base32)) begin
                w_fwd_word = merge_bytes(w_fwd_word, r_entries[r_head + PW'(i)].data,
                                         r_entries[r_head + PW'(i)].mask);
            end
        end
    end

    sb_lane_align #(.IS_LOAD(1'b1)) u_ld_align (
        .i_data     (w_fwd_word),
        .i_off      (w_off),
        .i_size     (bus.SIZE),
        .i_unsigned (bus.UNSIGNED),
        .o_data     (w_ld_data)
    );

    always_comb begin
        bus.MEM_WE   = w_drain;
        bus.MEM_ADDR = w_drain ? r_entries[r_head].base[ADDR_WIDTH-1:0] : w_base;
        bus.MEM_WD   = w_drain ? merge_bytes(bus.MEM_RD, r_entries[r_head].data,
                                             r_entries[r_head].mask) : 32'h0;
        bus.RD       = w_ld ? w_ld_data : 32'h0;
        bus.MISALIGN = w_mis;
        bus.STALL    = !reset && bus.FLUSH && !w_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
        end else begin
            if (w_drain) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PW'(1);
            end
            if (w_coal) begin
                r_entries[w_young_idx].data <= merge_bytes(r_entries[w_young_idx].data, w_st_lane, w_mask);
                r_entries[w_young_idx].mask <= r_entries[w_young_idx].mask | w_mask;
            end
            // When full, head and tail coincide; this later write overrides the pop's valid clear.
            if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, base: w_base32, mask: w_mask, data: w_st_lane};
                r_tail            <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_drain);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized scoreboard bench for store_buffer
module tb_store_buffer;
    import sb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_WIDTH(32)) bus ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ma;

    assign ma = bus.MEM_ADDR[7:0];
    always_comb bus.MEM_RD = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    always @(posedge clk) begin
        if (bus.MEM_WE) begin
            for (int i = 0; i < 4; i++) mem[ma + 8'(i)] <= bus.MEM_WD[8*i +: 8];
        end
    end

    typedef struct {
        int          base;
        logic [3:0]  mask;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        bit          we;
        bit          chk_addr;
        int          addr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          stall;
        bit          mis;
        int          cnt;
    } exp_t;

    pend_t pend[$];
    exp_t  expq[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[(base + 3) & 255], ref_mem[(base + 2) & 255],
                ref_mem[(base + 1) & 255], ref_mem[base & 255]};
    endfunction

    function automatic logic [31:0] overlay(input logic [31:0] w, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] r = w;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Reference: a list of pending stores in program order plus a byte memory.
    task automatic model(input bit rst, input bit ld, input bit st, input logic [1:0] size,
                         input bit uns, input int addr, input logic [31:0] wd, input bit flush);
        exp_t e;
        int base = addr & ~3;
        int off = addr & 3;
        int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        logic [3:0] mask = 4'(((1 << n) - 1) << off);
        bit mis = (ld || st) && (off + n > 4);
        bit drain;
        logic [31:0] w;
        logic [31:0] sh;
        e = '{default: 0};
        e.cnt = pend.size();
        if (rst) begin
            e.cnt = -1;
            pend.delete();
            expq.push_back(e);
            return;
        end
        e.mis   = mis;
        e.stall = flush && (pend.size() > 0);
        if (mis || pend.size() == 0) drain = 0;
        else if (!ld) drain = 1;
        else drain = st && (pend.size() == DEPTH) && (pend[$].base != base);
        if (drain) begin
            e.we = 1; e.chk_addr = 1; e.addr = pend[0].base;
            e.wd = overlay(ref_word(pend[0].base), pend[0].mask, pend[0].data);
            for (int i = 0; i < 4; i++) ref_mem[(pend[0].base + i) & 255] = e.wd[8*i +: 8];
            void'(pend.pop_front());
        end else if (ld && !st) begin
            e.chk_addr = 1; e.addr = base;
        end
        if (ld && !st && !mis) begin
            w = ref_word(base);
            foreach (pend[i]) if (pend[i].base == base) w = overlay(w, pend[i].mask, pend[i].data);
            sh = w >> (8 * off);
            if (size == 2'd0) e.rd = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            else if (size == 2'd1) e.rd = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            else e.rd = sh;
        end
        if (st && !mis) begin
            if (pend.size() > 0 && pend[$].base == base) begin
                pend[$].data = overlay(pend[$].data, mask, wd << (8 * off));
                pend[$].mask = pend[$].mask | mask;
            end else begin
                pend.push_back('{base: base, mask: mask, data: wd << (8 * off)});
            end
        end
        expq.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit ld, input bit st, input logic [1:0] size,
                         input bit uns, input int addr, input logic [31:0] wd, input bit flush);
        @(posedge clk);
        #1;
        reset = rst; bus.LD_REQ = ld; bus.ST_REQ = st; bus.SIZE = size;
        bus.UNSIGNED = uns; bus.ADDR = addr; bus.WD = wd; bus.FLUSH = flush;
        model(rst, ld, st, size, uns, addr, wd, flush);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'd0, 0, 0, 32'h0, 0);
    endtask

    task automatic drain_all();
        for (int k = 0; k < 12 && pend.size() > 0; k++) drive(0, 0, 0, 2'd0, 0, 0, 32'h0, 1);
        check("drain_bound", 32'(pend.size()), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("mem_we", 32'(bus.MEM_WE), 32'(e.we));
                if (e.chk_addr) check("mem_addr", bus.MEM_ADDR, e.addr);
                if (e.we) check("mem_wd", bus.MEM_WD, e.wd);
                check("rd", bus.RD, e.rd);
                check("stall", 32'(bus.STALL), 32'(e.stall));
                check("misalign", 32'(bus.MISALIGN), 32'(e.mis));
                if (e.cnt >= 0) check("count", 32'(dut.r_count), e.cnt);
            end
        end
    end

    initial begin : stim
        int pulses;
        reset = 1'b1;
        bus.LD_REQ = 0; bus.ST_REQ = 0; bus.SIZE = 0; bus.UNSIGNED = 0;
        bus.ADDR = 0; bus.WD = 0; bus.FLUSH = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[32] = 8'h44; mem[33] = 8'h33; mem[34] = 8'h22; mem[35] = 8'h11;
        for (int i = 32; i < 36; i++) ref_mem[i] = mem[i];

        drive(1, 0, 0, 2'd0, 0, 0, 32'h0, 1);
        check("reset_we", 32'(bus.MEM_WE), 32'd0);
        drive(1, 0, 0, 2'd0, 0, 0, 32'h0, 0);

        drive(0, 0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0);
        idle();
        check("sw_we", 32'(bus.MEM_WE), 32'd1);
        check("sw_addr", bus.MEM_ADDR, 32'h10);
        check("sw_wd", bus.MEM_WD, 32'hDEADBEEF);

        drive(0, 0, 1, SZ_BYTE, 0, 32'h21, 32'hAA, 0);
        drive(0, 1, 0, SZ_BYTE, 1, 32'h21, 32'h0, 0);
        check("lbu_fwd", bus.RD, 32'h000000AA);
        drive(0, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 0);
        check("lw_fwd", bus.RD, 32'h1122AA44);
        idle();

        drive(0, 1, 1, SZ_BYTE, 0, 32'h31, 32'h80, 0);
        drive(0, 1, 1, SZ_BYTE, 0, 32'h31, 32'h7F, 0);
        drive(0, 1, 0, SZ_BYTE, 0, 32'h31, 32'h0, 0);
        check("lb_coal", bus.RD, 32'h0000007F);
        check("coal_count", 32'(dut.r_count), 32'd1);
        drive(0, 1, 1, SZ_BYTE, 0, 32'h31, 32'h80, 0);
        drive(0, 1, 0, SZ_BYTE, 0, 32'h31, 32'h0, 0);
        check("lb_sign", bus.RD, 32'hFFFFFF80);
        drain_all();

        for (int i = 0; i < DEPTH; i++) drive(0, 1, 1, SZ_WORD, 0, 32'h50 + 4 * i, $urandom, 0);
        drive(0, 1, 1, SZ_WORD, 0, 32'h60, 32'h0BADF00D, 0);
        check("full_we", 32'(bus.MEM_WE), 32'd1);
        check("full_addr", bus.MEM_ADDR, 32'h50);
        check("full_stall", 32'(bus.STALL), 32'd0);
        drive(0, 1, 0, SZ_WORD, 0, 32'h60, 32'h0, 0);
        check("full_count", 32'(dut.r_count), 32'd4);
        check("full_fwd", bus.RD, 32'h0BADF00D);

        drive(0, 0, 1, SZ_HALF, 0, 32'h43, 32'h1234, 0);
        check("sh_misalign", 32'(bus.MISALIGN), 32'd1);
        check("sh_count", 32'(dut.r_count), 32'd4);
        drain_all();

        for (int i = 0; i < 3; i++) drive(0, 1, 1, SZ_WORD, 0, 32'h70 + 4 * i, 32'hC0DE0000 + i, 0);
        drive(1, 0, 0, SZ_WORD, 0, 0, 32'h0, 1);
        check("rst_we", 32'(bus.MEM_WE), 32'd0);
        check("rst_stall", 32'(bus.STALL), 32'd0);
        idle();
        check("rst_count", 32'(dut.r_count), 32'd0);

        drive(0, 1, 1, SZ_HALF, 0, 32'h82, 32'h5555, 0);
        drive(0, 1, 1, SZ_BYTE, 0, 32'h88, 32'h66, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 2'd0, 0, 0, 32'h0, 1);
            check("flush_stall", 32'(bus.STALL), (i < 2) ? 32'd1 : 32'd0);
            pulses += int'(bus.MEM_WE);
        end
        check("flush_pulses", 32'(pulses), 32'd2);

        for (int c = 0; c < 600; c++) begin
            int op = $urandom_range(0, 3);
            drive(0, op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom),
                  32'h80 + $urandom_range(0, 31), $urandom, 0);
        end
        drain_all();
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
